// File: rtl/sccb_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// sccb_cfg_sequencer
// Walks a register-init table and issues one SCCB write per entry to the SCCB
// master, so the sensor is configured before the packetizer is enabled.
// Table entries are {reg_addr, reg_data}:
//   16'hFFFF      end of table
//   {8'hF0, n}    wait n*DELAY_TICK clk cycles (n = 0 means no wait)
//   anything else one SCCB write of reg_data to reg_addr
// A NACKed write is retried up to RETRIES attempts in total; after that the
// sequence stops in an error state that records the failing table index.
//
// Ports
//   clk        camera-domain clock
//   reset_b    asynchronous active-low reset
//   start      single-cycle pulse, runs the table from entry 0 (ignored while busy)
//   rom_addr   table read address
//   rom_data   table word, valid one clk after rom_addr changes
//   sccb_req   one-cycle write request to the SCCB master
//   sccb_id    device write ID (DEV_ID)
//   sccb_addr  register address of the current write
//   sccb_data  register data of the current write
//   sccb_busy  master transaction in progress
//   sccb_done  one-cycle end-of-transaction pulse
//   sccb_nack  slave did not acknowledge (qualified by sccb_done)
//   busy       sequence in progress
//   cfg_done   table completed without error (held until start/reset)
//   cfg_error  an entry exhausted its retries (held until start/reset)
//   err_index  table index of the failing entry
// ---------------------------------------------------------------------------
module sccb_cfg_sequencer #(
    parameter int unsigned AW         = 6,
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int unsigned RETRIES    = 3,
    parameter int unsigned DELAY_TICK = 40000
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          sccb_req,
    output logic [7:0]    sccb_id,
    output logic [7:0]    sccb_addr,
    output logic [7:0]    sccb_data,
    input  logic          sccb_busy,
    input  logic          sccb_done,
    input  logic          sccb_nack,
    output logic          busy,
    output logic          cfg_done,
    output logic          cfg_error,
    output logic [AW-1:0] err_index
);

    // Delay counter must hold 255*DELAY_TICK; retry counter must hold RETRIES.
    localparam int unsigned DCW = $clog2(255 * DELAY_TICK + 1);
    localparam int unsigned RCW = $clog2(RETRIES + 1);

    localparam logic [15:0] END_MARKER = 16'hFFFF;
    localparam logic [7:0]  DELAY_ADDR = 8'hF0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   rom_addr_q;
    logic [7:0]      sccb_addr_q;
    logic [7:0]      sccb_data_q;
    logic            busy_q;
    logic            cfg_done_q;
    logic            cfg_error_q;
    logic [AW-1:0]   err_index_q;
    logic [RCW-1:0]  retry_q;
    logic [DCW-1:0]  dly_q;

    logic [RCW-1:0]  retry_d;
    logic [DCW-1:0]  dly_d;
    logic            retry_left;
    logic            table_last;

    // Attempt count after a NACK, and whether another attempt is allowed.
    assign retry_d    = retry_q + RCW'(1);
    assign retry_left = (32'(retry_d) < RETRIES);

    // Delay length of the entry currently presented by the table.
    assign dly_d      = DCW'(rom_data[7:0]) * DCW'(DELAY_TICK);

    assign table_last = &rom_addr_q;

    // Sequencer FSM: state, table pointer, latched write and status registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            sccb_addr_q <= '0;
            sccb_data_q <= '0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
            err_index_q <= '0;
            retry_q     <= '0;
            dly_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        cfg_done_q  <= 1'b0;
                        cfg_error_q <= 1'b0;
                        rom_addr_q  <= '0;
                        retry_q     <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end

                // Table read latency.
                S_FETCH: begin
                    state_q <= S_DECODE;
                end

                S_DECODE: begin
                    if (rom_data == END_MARKER) begin
                        busy_q     <= 1'b0;
                        cfg_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (rom_data[15:8] == DELAY_ADDR) begin
                        if (rom_data[7:0] == 8'd0) begin
                            state_q <= S_NEXT;
                        end else begin
                            dly_q   <= dly_d;
                            state_q <= S_DELAY;
                        end
                    end else begin
                        sccb_addr_q <= rom_data[15:8];
                        sccb_data_q <= rom_data[7:0];
                        state_q     <= S_ISSUE;
                    end
                end

                // Request is decoded from this state; leave once the master takes it.
                S_ISSUE: begin
                    if (!sccb_busy) begin
                        state_q <= S_WAIT;
                    end
                end

                // No timeout: a master that never answers keeps the sequence here.
                S_WAIT: begin
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            state_q <= S_NEXT;
                        end else if (retry_left) begin
                            retry_q <= retry_d;
                            state_q <= S_ISSUE;
                        end else begin
                            retry_q     <= retry_d;
                            err_index_q <= rom_addr_q;
                            busy_q      <= 1'b0;
                            cfg_error_q <= 1'b1;
                            state_q     <= S_ERROR;
                        end
                    end
                end

                // Residence is exactly the loaded count: exit in the cycle it reads 1.
                S_DELAY: begin
                    if (dly_q == DCW'(1)) begin
                        dly_q   <= '0;
                        state_q <= S_NEXT;
                    end else begin
                        dly_q <= dly_q - DCW'(1);
                    end
                end

                // Last table slot ends the sequence rather than wrapping to 0.
                S_NEXT: begin
                    retry_q <= '0;
                    if (table_last) begin
                        busy_q     <= 1'b0;
                        cfg_done_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        rom_addr_q <= rom_addr_q + AW'(1);
                        state_q    <= S_FETCH;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Request goes out in the first ISSUE cycle the master is idle, so it is
    // decoded from the registered state rather than registered itself.
    assign sccb_req  = (state_q == S_ISSUE) && !sccb_busy;

    assign rom_addr  = rom_addr_q;
    assign sccb_id   = DEV_ID;
    assign sccb_addr = sccb_addr_q;
    assign sccb_data = sccb_data_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_error = cfg_error_q;
    assign err_index = err_index_q;

endmodule

// File: doc/sccb_cfg_sequencer.md
Name: sccb_cfg_sequencer

Overview:
- Walks a register-init table and issues one SCCB write per entry to the SCCB master.
- Runs on the camera clock. It brings the sensor to a known configuration before the packetizer is enabled.
- Provides per-entry retry on NACK, table-embedded delays, and end-of-table detection.
- Reports busy, done and error status to the PC-side control logic.

Parameters:
- AW, 6: table address width; table holds 2**AW entries.
- DEV_ID, 8'h42: SCCB device write ID driven on sccb_id.
- RETRIES, 3: maximum attempts per entry (first try included) before error.
- DELAY_TICK, 40000: clk cycles per delay unit (1 ms at 40 MHz).

Ports:
- clk  in  1  camera-domain clock (camclk40)
- reset_b  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins sequence at entry 0
- rom_addr  out  AW  table read address
- rom_data  in  16  {reg_addr[15:8], reg_data[7:0]}; valid one clk after rom_addr changes
- sccb_req  out  1  one-cycle write request to SCCB master
- sccb_id  out  8  device ID (constant DEV_ID)
- sccb_addr  out  8  register address, held stable from ISSUE until the next FETCH
- sccb_data  out  8  register data, held like sccb_addr
- sccb_busy  in  1  master transaction in progress
- sccb_done  in  1  one-cycle pulse at end of transaction
- sccb_nack  in  1  qualified by sccb_done; 1 = slave did not acknowledge
- busy  out  1  sequence in progress
- cfg_done  out  1  level; table completed without error
- cfg_error  out  1  level; an entry exhausted its retries
- err_index  out  AW  index of the failing entry (valid while cfg_error=1)

Behaviour:
- Reset (reset_b=0, async): state=IDLE, rom_addr=0, sccb_req=0, sccb_addr=0, sccb_data=0, busy=0, cfg_done=0, cfg_error=0, err_index=0, retry count=0, delay counter=0.
- A reset asserted mid-operation aborts immediately. A transaction already in flight in the master is abandoned and its sccb_done is ignored after reset.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Clear cfg_done and cfg_error; set rom_addr=0 and retry=0; go to FETCH.
  - busy=1 in every state except IDLE, DONE and ERROR.
- Start while busy=1 is ignored.
- FETCH: one wait cycle for table latency; then DECODE.
- DECODE: rom_data is sampled.
  - 16'hFFFF (end marker): go to DONE.
  - reg_addr=8'hF0 (delay entry): load delay counter = reg_data*DELAY_TICK and go to DELAY. If reg_data=0, go straight to NEXT.
  - Otherwise: latch sccb_addr and sccb_data; go to ISSUE.
- ISSUE: wait while sccb_busy=1. In the first cycle with sccb_busy=0, sccb_req=1 for exactly that cycle; then WAIT.
- Latency: start at cycle 0 → FETCH at cycle 1 → DECODE at cycle 2 → sccb_req at cycle 3, provided sccb_busy=0.
- WAIT:
  - sccb_done & ~sccb_nack: go to NEXT.
  - sccb_done & sccb_nack: retry+1. If retry+1 < RETRIES, go to ISSUE (same entry, fresh sccb_req); else err_index=rom_addr and go to ERROR.
  - No timeout is applied in WAIT.
- DELAY: decrement counter each clk; leave for NEXT in the cycle the counter reaches 1. Total DELAY residence = reg_data*DELAY_TICK cycles.
- NEXT: retry=0.
  - If rom_addr = 2**AW-1, go to DONE (table exhausted without marker; no wrap to 0).
  - Else rom_addr+1 and go to FETCH.
- DONE: cfg_done=1 held until the next start or reset.
- ERROR: cfg_error=1 held until the next start or reset. No further sccb_req.
- Simultaneous events:
  - sccb_done outside WAIT is ignored.
  - start coinciding with the entry into DONE is ignored; it is honoured from the following cycle.
- Widths: the delay counter is wide enough for 255*DELAY_TICK. The retry counter is wide enough for RETRIES.

Test Plan:
- Table {12 80},{11 01},{FFFF}; master acks after 5 cycles → exactly 2 sccb_req with addr/data 12/80 then 11/01; first req at cycle 3 after start; cfg_done=1, busy=0.
- Entry {3A 04} NACKed once then acked → 2 sccb_req with identical addr/data; sequence continues; cfg_error=0.
- Entry index 2 always NACKed, RETRIES=3 → 3 requests then cfg_error=1, err_index=2; no further sccb_req; next start clears cfg_error and restarts at entry 0.
- DELAY_TICK=10, entry {F0 03} between two writes → exactly 30 cycles in DELAY, no sccb_req; entry {F0 00} → no delay cycles.
- sccb_busy held high 20 cycles at ISSUE → sccb_req issued the first cycle after sccb_busy drops; start pulses during the sequence have no effect.
- Assert reset_b low during WAIT → all outputs reach reset values immediately; a late sccb_done is ignored; full table (2**AW entries, no marker) ends in DONE with rom_addr=2**AW-1.
